// File: rtl/bullet_controller.sv
// Tank bullet launch/flight/cooldown controller with pixel hit-test output.
// Optional macro BULLET_COOLDOWN_EN enables the frame-counted cooldown state.
module bullet_controller #(
    parameter logic [9:0] BULLET_SIZE     = 10'd8,
    parameter logic [9:0] BULLET_STEP     = 10'd4,
    parameter logic [9:0] SCREEN_W        = 10'd640,
    parameter logic [9:0] SCREEN_H        = 10'd480,
    parameter logic [4:0] COOLDOWN_FRAMES = 5'd16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic       hit,
    input  logic [9:0] tankX,
    input  logic [9:0] tankY,
    input  logic [2:0] tank_dir,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       is_shooting,
    output logic       is_bullet,
    output logic [9:0] bullet_X,
    output logic [9:0] bullet_Y,
    output logic [2:0] bullet_dir
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FLY      = 2'd1;
    localparam logic [1:0] COOLDOWN = 2'd2;

`ifdef BULLET_COOLDOWN_EN
    localparam logic [1:0] END_FLIGHT = COOLDOWN;
`else
    localparam logic [1:0] END_FLIGHT = IDLE;
`endif

    localparam logic [10:0] BS    = {1'b0, BULLET_SIZE};
    localparam logic [10:0] ST    = {1'b0, BULLET_STEP};
    localparam logic [10:0] OFF   = (11'd32 - BS) >> 1;
    localparam logic [10:0] X_MAX = {1'b0, SCREEN_W} - BS;
    localparam logic [10:0] Y_MAX = {1'b0, SCREEN_H} - BS;

    logic [1:0]  state;
    logic        pending;
    logic [1:0]  fc_sync, fire_sync;
    logic        fc_q, fire_q;
    logic        tick, fire_evt;
    logic [10:0] tx, ty, bx, by;
    logic [10:0] sx, sy, nx, ny;
    logic        dir_ok, spawn_on, move_on;

    assign tick     = fc_sync[1] & ~fc_q;
    assign fire_evt = fire_sync[1] & ~fire_q;

    assign tx = {1'b0, tankX};
    assign ty = {1'b0, tankY};
    assign bx = {1'b0, bullet_X};
    assign by = {1'b0, bullet_Y};

    // Negative results wrap to >= 2040 in 11 bits, so the max test also rejects them.
    always_comb begin
        sx     = tx;
        sy     = ty;
        dir_ok = 1'b1;
        case (tank_dir)
            3'b001:  begin sx = tx + OFF;    sy = ty - BS;     end
            3'b100:  begin sx = tx + OFF;    sy = ty + 11'd32; end
            3'b010:  begin sx = tx + 11'd32; sy = ty + OFF;    end
            3'b011:  begin sx = tx - BS;     sy = ty + OFF;    end
            default: dir_ok = 1'b0;
        endcase
    end

    always_comb begin
        nx = bx;
        ny = by;
        case (bullet_dir)
            3'b001:  ny = by - ST;
            3'b100:  ny = by + ST;
            3'b010:  nx = bx + ST;
            3'b011:  nx = bx - ST;
            default: ;
        endcase
    end

    assign spawn_on = (sx <= X_MAX) && (sy <= Y_MAX);
    assign move_on  = (nx <= X_MAX) && (ny <= Y_MAX);

`ifdef BULLET_COOLDOWN_EN
    logic [4:0] cd_cnt;
`else
    logic unused_cd;
    assign unused_cd = ^COOLDOWN_FRAMES;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            pending    <= 1'b0;
            fc_sync    <= 2'b00;
            fire_sync  <= 2'b00;
            fc_q       <= 1'b0;
            fire_q     <= 1'b0;
            bullet_X   <= 10'd0;
            bullet_Y   <= 10'd0;
            bullet_dir <= 3'b000;
`ifdef BULLET_COOLDOWN_EN
            cd_cnt     <= 5'd0;
`endif
        end else begin
            fc_sync   <= {fc_sync[0], frame_clk};
            fire_sync <= {fire_sync[0], fire};
            fc_q      <= fc_sync[1];
            fire_q    <= fire_sync[1];
            case (state)
                IDLE: begin
                    if (pending && tick) begin
                        pending <= 1'b0;
                        if (dir_ok) begin
                            bullet_dir <= tank_dir;
                            if (spawn_on) begin
                                bullet_X <= sx[9:0];
                                bullet_Y <= sy[9:0];
                                state    <= FLY;
                            end else begin
                                state <= END_FLIGHT;
                            end
                        end
                    end else if (fire_evt) begin
                        pending <= 1'b1;
                    end
                end
                FLY: begin
                    if (hit) begin
                        state <= END_FLIGHT;
                    end else if (tick) begin
                        if (move_on) begin
                            bullet_X <= nx[9:0];
                            bullet_Y <= ny[9:0];
                        end else begin
                            state <= END_FLIGHT;
                        end
                    end
                end
                COOLDOWN: begin
`ifdef BULLET_COOLDOWN_EN
                    if (tick) begin
                        if (cd_cnt == COOLDOWN_FRAMES - 5'd1) begin
                            cd_cnt <= 5'd0;
                            state  <= IDLE;
                        end else begin
                            cd_cnt <= cd_cnt + 5'd1;
                        end
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign is_shooting = (state == FLY);

    assign is_bullet = is_shooting
                    && ({1'b0, DrawX} >= bx) && ({1'b0, DrawX} < bx + BS)
                    && ({1'b0, DrawY} >= by) && ({1'b0, DrawY} < by + BS);

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller with an in-bench behavioural model.
// Build with BULLET_COOLDOWN_EN defined to exercise the cooldown variant.
module tb_bullet_controller;

    localparam int BS  = 8;
    localparam int ST  = 4;
    localparam int SW  = 640;
    localparam int SH  = 480;
    localparam int CDF = 16;

    localparam int M_IDLE = 0;
    localparam int M_FLY  = 1;
    localparam int M_CD   = 2;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       fire = 1'b0;
    logic       hit = 1'b0;
    logic [9:0] tankX = '0;
    logic [9:0] tankY = '0;
    logic [2:0] tank_dir = '0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       is_shooting;
    logic       is_bullet;
    logic [9:0] bullet_X;
    logic [9:0] bullet_Y;
    logic [2:0] bullet_dir;

    bullet_controller dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .fire       (fire),
        .hit        (hit),
        .tankX      (tankX),
        .tankY      (tankY),
        .tank_dir   (tank_dir),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .is_shooting(is_shooting),
        .is_bullet  (is_bullet),
        .bullet_X   (bullet_X),
        .bullet_Y   (bullet_Y),
        .bullet_dir (bullet_dir)
    );

    always #5 Clk = ~Clk;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    int m_state, m_pend, m_cnt, m_x, m_y, m_dir;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic bit on_scr(input int x, input int y);
        return x >= 0 && x + BS <= SW && y >= 0 && y + BS <= SH;
    endfunction

    task automatic m_reset();
        m_state = M_IDLE;
        m_pend  = 0;
        m_cnt   = 0;
        m_x     = 0;
        m_y     = 0;
        m_dir   = 0;
    endtask

    task automatic m_end_flight();
`ifdef BULLET_COOLDOWN_EN
        m_state = M_CD;
        m_cnt   = 0;
`else
        m_state = M_IDLE;
`endif
    endtask

    task automatic m_fire();
        if (m_state == M_IDLE) m_pend = 1;
    endtask

    task automatic m_hit();
        if (m_state == M_FLY) m_end_flight();
    endtask

    task automatic m_tick();
        int off, sx, sy, nx, ny, d;
        off = (32 - BS) / 2;
        d   = int'(tank_dir);
        if (m_state == M_IDLE) begin
            if (m_pend != 0) begin
                m_pend = 0;
                if (d >= 1 && d <= 4) begin
                    sx = int'(tankX);
                    sy = int'(tankY);
                    if (d == 1) begin sx += off; sy -= BS; end
                    if (d == 4) begin sx += off; sy += 32; end
                    if (d == 2) begin sx += 32;  sy += off; end
                    if (d == 3) begin sx -= BS;  sy += off; end
                    m_dir = d;
                    if (on_scr(sx, sy)) begin
                        m_x = sx;
                        m_y = sy;
                        m_state = M_FLY;
                    end else begin
                        m_end_flight();
                    end
                end
            end
        end else if (m_state == M_FLY) begin
            nx = m_x;
            ny = m_y;
            if (m_dir == 1) ny -= ST;
            if (m_dir == 4) ny += ST;
            if (m_dir == 2) nx += ST;
            if (m_dir == 3) nx -= ST;
            if (on_scr(nx, ny)) begin
                m_x = nx;
                m_y = ny;
            end else begin
                m_end_flight();
            end
        end else begin
            m_cnt++;
            if (m_cnt == CDF) begin
                m_cnt   = 0;
                m_state = M_IDLE;
            end
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en && Reset_n) begin
            chk("is_shooting", 32'(is_shooting), 32'(m_state == M_FLY));
            chk("bullet_X", 32'(bullet_X), m_x);
            chk("bullet_Y", 32'(bullet_Y), m_y);
            chk("bullet_dir", 32'(bullet_dir), m_dir);
            chk("is_bullet", 32'(is_bullet),
                32'(m_state == M_FLY
                    && int'(DrawX) >= m_x && int'(DrawX) < m_x + BS
                    && int'(DrawY) >= m_y && int'(DrawY) < m_y + BS));
        end
    end

    task automatic set_tank(input int x, input int y, input int d);
        tankX    = 10'(x);
        tankY    = 10'(y);
        tank_dir = 3'(d);
    endtask

    task automatic do_tick();
        chk_en = 1'b0;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        m_tick();
        #1 chk_en = 1'b1;
    endtask

    task automatic do_fire();
        chk_en = 1'b0;
        @(negedge Clk);
        fire = 1'b1;
        repeat (4) @(negedge Clk);
        fire = 1'b0;
        repeat (4) @(negedge Clk);
        m_fire();
        #1 chk_en = 1'b1;
    endtask

    task automatic do_hit();
        chk_en = 1'b0;
        @(negedge Clk);
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
        m_hit();
        #1 chk_en = 1'b1;
    endtask

    task automatic do_tick_hit();
        chk_en = 1'b0;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        m_hit();
        #1 chk_en = 1'b1;
    endtask

    task automatic flush_cooldown();
`ifdef BULLET_COOLDOWN_EN
        repeat (CDF) do_tick();
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " is_shooting"}, 32'(is_shooting), 0);
        chk({tag, " is_bullet"}, 32'(is_bullet), 0);
        chk({tag, " bullet_X"}, 32'(bullet_X), 0);
        chk({tag, " bullet_Y"}, 32'(bullet_Y), 0);
        chk({tag, " bullet_dir"}, 32'(bullet_dir), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        m_reset();
        #12;
        chk_all_zero("reset");
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge Clk);

        // launch right and fly
        set_tank(100, 200, 2);
        do_fire();
        do_tick();
        chk("launch shooting", 32'(is_shooting), 1);
        chk("launch X", 32'(bullet_X), 132);
        chk("launch Y", 32'(bullet_Y), 212);
        chk("launch dir", 32'(bullet_dir), 2);
        repeat (3) do_tick();
        chk("fly X", 32'(bullet_X), 144);

        // fire and tank motion during flight
        do_fire();
        set_tank(0, 0, 1);
        do_tick();
        chk("ignore tank X", 32'(bullet_X), 148);
        chk("ignore tank Y", 32'(bullet_Y), 212);
        do_hit();
        chk("hit stop", 32'(is_shooting), 0);
        chk("hit hold X", 32'(bullet_X), 148);
        flush_cooldown();
        do_tick();
        chk("no relaunch", 32'(is_shooting), 0);

        // hit outside flight, left spawn
        set_tank(300, 100, 3);
        do_fire();
        do_hit();
        do_tick();
        chk("left X", 32'(bullet_X), 292);
        chk("left Y", 32'(bullet_Y), 112);
        chk("left dir", 32'(bullet_dir), 3);
        do_tick();
        chk("left move", 32'(bullet_X), 288);
        do_hit();
        flush_cooldown();

        // down spawn
        set_tank(300, 100, 4);
        do_fire();
        do_tick();
        chk("down X", 32'(bullet_X), 312);
        chk("down Y", 32'(bullet_Y), 132);
        do_tick();
        chk("down move", 32'(bullet_Y), 136);
        do_hit();
        flush_cooldown();

        // right edge
        set_tank(596, 100, 2);
        do_fire();
        do_tick();
        chk("edge spawn X", 32'(bullet_X), 628);
        do_tick();
        chk("edge last X", 32'(bullet_X), 632);
        chk("edge still flying", 32'(is_shooting), 1);
        do_tick();
        chk("edge stop", 32'(is_shooting), 0);
        chk("edge hold X", 32'(bullet_X), 632);
        flush_cooldown();

        // off-screen spawn upward
        set_tank(100, 4, 1);
        do_fire();
        do_tick();
        chk("offscreen spawn", 32'(is_shooting), 0);
        flush_cooldown();
        set_tank(100, 200, 1);
        do_fire();
        do_tick();
        chk("after offscreen", 32'(is_shooting), 1);
        chk("up X", 32'(bullet_X), 112);
        chk("up Y", 32'(bullet_Y), 192);

        // hit coincident with tick
        do_tick_hit();
        chk("tickhit stop", 32'(is_shooting), 0);
        chk("tickhit hold Y", 32'(bullet_Y), 192);
        flush_cooldown();
        do_fire();
        do_tick();
        chk("relaunch", 32'(is_shooting), 1);
        do_tick();
        chk("relaunch move", 32'(bullet_Y), 188);
        do_hit();
        flush_cooldown();

        // left off-screen, invalid direction
        set_tank(4, 100, 3);
        do_fire();
        do_tick();
        chk("left offscreen", 32'(is_shooting), 0);
        flush_cooldown();
        set_tank(100, 100, 0);
        do_fire();
        do_tick();
        chk("invalid dir", 32'(is_shooting), 0);
        set_tank(100, 100, 2);
        do_tick();
        chk("pending cleared", 32'(is_shooting), 0);
        do_fire();
        do_tick();
        chk("valid after invalid", 32'(bullet_X), 132);
        do_hit();
        flush_cooldown();

        // pixel hit-test
        set_tank(168, 288, 2);
        do_fire();
        do_tick();
        chk("pix X", 32'(bullet_X), 200);
        chk("pix Y", 32'(bullet_Y), 300);
        DrawX = 10'd207; DrawY = 10'd307; #1;
        chk("pix in corner", 32'(is_bullet), 1);
        DrawX = 10'd208; DrawY = 10'd300; #1;
        chk("pix right out", 32'(is_bullet), 0);
        DrawX = 10'd199; #1;
        chk("pix left out", 32'(is_bullet), 0);
        DrawX = 10'd200; DrawY = 10'd308; #1;
        chk("pix below out", 32'(is_bullet), 0);
        DrawY = 10'd299; #1;
        chk("pix above out", 32'(is_bullet), 0);
        DrawY = 10'd300; #1;
        chk("pix origin", 32'(is_bullet), 1);
        repeat (2) @(negedge Clk);

        // asynchronous reset mid-flight
        #3;
        chk_en  = 1'b0;
        Reset_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        m_reset();
        repeat (2) @(negedge Clk);
        #1 Reset_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge Clk);
        do_fire();
        do_tick();
        chk("post reset launch", 32'(is_shooting), 1);
        chk("post reset X", 32'(bullet_X), 200);
        repeat (2) @(negedge Clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bullet_controller.md
BULLET_CONTROLLER -- requirements
Module: bullet_controller

Interface
REQ-001 Parameter BULLET_SIZE, default 10'd8: bullet sprite edge length in pixels (square).
REQ-002 Parameter BULLET_STEP, default 10'd4: pixels moved per frame tick.
REQ-003 Parameter SCREEN_W, default 10'd640; SCREEN_H, default 10'd480: visible area.
REQ-004 Parameter COOLDOWN_FRAMES, default 5'd16: frame ticks spent in COOLDOWN.
REQ-005 Clk  in  1  system clock; all state changes on its rising edge.
REQ-006 Reset_n  in  1  reset, asynchronous, active-low.
REQ-007 frame_clk  in  1  vertical-sync-rate strobe, asynchronous to Clk.
REQ-008 fire  in  1  fire button level, asynchronous.
REQ-009 hit  in  1  one-Clk pulse: bullet struck a target.
REQ-010 tankX, tankY  in  10 each  owning tank top-left corner; tank is 32x32.
REQ-011 tank_dir  in  3  001 up, 010 right, 011 left, 100 down; other codes invalid.
REQ-012 DrawX, DrawY  in  10 each  current pixel coordinates.
REQ-013 is_shooting  out  1  bullet in flight.
REQ-014 is_bullet  out  1  current pixel lies inside the bullet.
REQ-015 bullet_X, bullet_Y  out  10 each  bullet top-left corner.
REQ-016 bullet_dir  out  3  direction latched at launch, same encoding as tank_dir.

Function
REQ-017 frame_clk and fire each pass through a 2-flop synchronizer; frame tick = one-cycle pulse on synchronized 0->1 edge of frame_clk; fire event = one-cycle pulse on synchronized 0->1 edge of fire.
REQ-018 States: IDLE, FLY, COOLDOWN.
REQ-019 IDLE: fire event sets a pending flag; pending is cleared on exit from IDLE and is never set outside IDLE (fire in FLY/COOLDOWN is discarded).
REQ-020 IDLE with pending and frame tick: latch tank_dir into bullet_dir and spawn; invalid tank_dir clears pending and stays IDLE.
REQ-021 Spawn position: up (tankX+12, tankY-8); down (tankX+12, tankY+32); right (tankX+32, tankY+12); left (tankX-8, tankY+12), with offsets scaled as (32-BULLET_SIZE)/2 and BULLET_SIZE.
REQ-022 Spawn fully on-screen -> FLY, is_shooting=1 next cycle; spawn off-screen (e.g. up with tankY<8) -> COOLDOWN, is_shooting stays 0.
REQ-023 All position arithmetic uses 11-bit intermediates; on-screen means X>=0, X+BULLET_SIZE<=SCREEN_W, Y>=0, Y+BULLET_SIZE<=SCREEN_H; no wrap-around.
REQ-024 FLY, frame tick: move BULLET_STEP along bullet_dir; if the next position is off-screen, do not update position, go COOLDOWN, is_shooting=0.
REQ-025 FLY, hit pulse: go COOLDOWN next cycle, is_shooting=0; hit coincident with frame tick takes priority (position not updated).
REQ-026 hit outside FLY is ignored.
REQ-027 COOLDOWN: count frame ticks; after COOLDOWN_FRAMES ticks go IDLE.
REQ-028 is_bullet = is_shooting and bullet_X<=DrawX<bullet_X+BULLET_SIZE and bullet_Y<=DrawY<bullet_Y+BULLET_SIZE; combinational from registered state.
REQ-029 tankX/tankY/tank_dir are sampled only at spawn; later tank motion does not affect the bullet.

Reset
REQ-030 Reset_n low: state IDLE, pending 0, cooldown count 0, is_shooting 0, bullet_X 0, bullet_Y 0, bullet_dir 3'b000, synchronizer flops 0; is_bullet therefore 0.
REQ-031 Reset asserted mid-flight aborts immediately; first fire event after release is honoured normally.

Configuration
REQ-032 Macro BULLET_COOLDOWN_EN: defined -> COOLDOWN behaves per REQ-027; undefined -> every transition to COOLDOWN goes directly to IDLE and no cooldown counter exists.

Verification
REQ-033 tankX=100,tankY=200,dir=010, fire pulse, frame tick -> is_shooting=1, bullet (132,212); 3 more ticks -> (144,212).
REQ-034 tankY=4,dir=001, fire, tick -> is_shooting stays 0, state COOLDOWN; 16 ticks later IDLE, new fire accepted.
REQ-035 Bullet at X=628 heading right, tick -> next 632+8=640 on-screen, move; next tick -> 636+8>640, is_shooting=0, bullet_X holds 632.
REQ-036 In FLY, fire pulses and tank moves -> bullet path unchanged, no second launch after termination without new fire.
REQ-037 hit and frame tick same cycle in FLY -> is_shooting=0 next cycle, position unchanged; with BULLET_COOLDOWN_EN undefined, fire+tick next frame relaunches.
REQ-038 Bullet at (200,300): DrawX/DrawY=(207,307) -> is_bullet=1; (208,300) -> 0; Reset_n low mid-flight -> all outputs 0 asynchronously.
